// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Grants one write per cycle with registered wr_en/wr_addr/wr_data and a one-cycle ack.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_RO    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_nxt;
  logic [PW-1:0]         win;
  logic [PW-1:0]         win_hi;
  logic [PW-1:0]         win_lo;
  logic                  found_hi;
  logic                  found_lo;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    ack_nxt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  busy_nxt;
  logic                  wr_en_nxt;
  int                    cnt;

  // Stage p0: eligibility, round-robin pick and operand select
  always_comb begin
    // Masking the current ack holder keeps an already-consumed request from a second grant.
    elig     = req & ~ack;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    cnt      = 0;
    // Scanning downward leaves the lowest qualifying index in each candidate.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_lo   = PW'(i);
        found_lo = 1'b1;
        cnt      = cnt + 1;
        if (i >= int'(ptr)) begin
          win_hi   = PW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;

    sel_addr = '0;
    sel_data = '0;
    ack_nxt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win) begin
        sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ack_nxt[i] = found_lo;
      end
    end

    ptr_nxt   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    busy_nxt  = (cnt > 1);
    wr_en_nxt = found_lo && !((ZERO_RO != 0) && (sel_addr == '0));
  end

  // Stage p1: registered grant towards the register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      ack     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
    end else begin
      ack   <= ack_nxt;
      busy  <= busy_nxt;
      wr_en <= wr_en_nxt;
      if (found_lo) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        ptr     <= ptr_nxt;
      end
    end
  end

endmodule
